// File: rtl/ex_muldiv_if.sv
// Issue/result bundle between the ID/EX stage and the iterative multiply/divide unit.
// master drives the issue side; slave is the ex_muldiv unit.
interface ex_muldiv_if;
  logic        start_i;
  logic [2:0]  func3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  modport master (
    output start_i, func3_i, rs1_data_i, rs2_data_i, rd_i, flush_i,
    input  busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, func3_i, rs1_data_i, rs2_data_i, rd_i, flush_i,
    output busy_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// RV32M execute unit: 32-cycle shift-add multiplier and restoring divider on operand
// magnitudes, sharing one 64-bit accumulator; divide-by-zero and signed overflow finish at once.
module ex_muldiv (
  input  logic        clk_i,
  input  logic        rst_i,
  ex_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [1:0]  func3_q, func3_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [4:0]  rd_cap_q, rd_cap_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;

  logic        div_signed, a_signed, b_signed, sa_in, sb_in;
  logic        div_zero, div_ovf;
  logic [31:0] mag_a, mag_b, special_res;

  logic [32:0] mul_sum;
  logic [63:0] mul_next, mul_prod;
  logic [31:0] mul_res;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [31:0] quo, rem, div_res;

  // Operand signs are folded into magnitudes at issue; only the effective signs are kept.
  always_comb begin
    div_signed  = ~bus.func3_i[0];
    a_signed    = bus.func3_i[2] ? div_signed
                                 : (bus.func3_i[1:0] == 2'b01 || bus.func3_i[1:0] == 2'b10);
    b_signed    = bus.func3_i[2] ? div_signed : (bus.func3_i[1:0] == 2'b01);
    sa_in       = a_signed & bus.rs1_data_i[31];
    sb_in       = b_signed & bus.rs2_data_i[31];
    mag_a       = sa_in ? (32'd0 - bus.rs1_data_i) : bus.rs1_data_i;
    mag_b       = sb_in ? (32'd0 - bus.rs2_data_i) : bus.rs2_data_i;
    div_zero    = (bus.rs2_data_i == 32'd0);
    div_ovf     = div_signed && (bus.rs1_data_i == 32'h8000_0000)
                             && (bus.rs2_data_i == 32'hFFFF_FFFF);
    special_res = bus.func3_i[1] ? (div_zero ? bus.rs1_data_i : 32'd0)
                                 : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    mul_prod  = (sa_q ^ sb_q) ? (64'd0 - mul_next) : mul_next;
    mul_res   = (func3_q == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_sub   = div_shift[31:0] - opb_q;
    div_next  = div_ge ? {div_sub, acc_q[30:0], 1'b1}
                       : {div_shift[31:0], acc_q[30:0], 1'b0};
    quo       = div_next[31:0];
    rem       = div_next[63:32];
    div_res   = func3_q[1] ? (sa_q ? (32'd0 - rem) : rem)
                           : ((sa_q ^ sb_q) ? (32'd0 - quo) : quo);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    func3_d  = func3_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    rd_cap_d = rd_cap_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;

    case (state_q)
      MUL: begin
        cnt_d = cnt_q + 6'd1;
        acc_d = mul_next;
        if (cnt_q == 6'd31) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = mul_res;
          rd_out_d = rd_cap_q;
        end else begin
          busy_d = 1'b1;
        end
      end
      DIV: begin
        cnt_d = cnt_q + 6'd1;
        acc_d = div_next;
        if (cnt_q == 6'd31) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = div_res;
          rd_out_d = rd_cap_q;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == IDLE || state_q == DONE) && bus.start_i) begin
      func3_d  = bus.func3_i[1:0];
      rd_cap_d = bus.rd_i;
      sa_d     = sa_in;
      sb_d     = sb_in;
      cnt_d    = 6'd0;
      acc_d    = {32'd0, mag_a};
      opb_d    = mag_b;
      if (!bus.func3_i[2]) begin
        state_d = MUL;
        busy_d  = 1'b1;
      end else if (div_zero || div_ovf) begin
        state_d  = DONE;
        done_d   = 1'b1;
        result_d = special_res;
        rd_out_d = bus.rd_i;
      end else begin
        state_d = DIV;
        busy_d  = 1'b1;
      end
    end

    // Flush beats a same-cycle issue and leaves the last completed result visible.
    if (bus.flush_i) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      func3_q  <= 2'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      rd_cap_q <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      rd_out_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      func3_q  <= func3_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      rd_cap_q <= rd_cap_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: fixed vector table, hand-written corner sequences,
// and random operations checked against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  ex_muldiv_if bus ();

  ex_muldiv dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
    int          busy;
  } vec_t;

  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] pu;
    longint      pa, pb, p;
    int          ia, ib;
    logic [31:0] r;
    ia = $signed(a);
    ib = $signed(b);
    pu = {32'd0, a} * {32'd0, b};
    case (f)
      3'b000: r = pu[31:0];
      3'b001: begin pa = ia; pb = ib; p = pa * pb; r = p[63:32]; end
      3'b010: begin pa = ia; pb = longint'({32'd0, b}); p = pa * pb; r = p[63:32]; end
      3'b011: r = pu[63:32];
      3'b100: if (b == 32'd0) r = 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
              else r = ia / ib;
      3'b101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: if (b == 32'd0) r = a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
              else r = ia % ib;
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int refLatency(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit alignFirst, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    if (alignFirst) @(negedge clk);
    bus.start_i    = 1'b1;
    bus.func3_i    = f;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.rd_i       = rd;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
  endtask

  task automatic waitDone(output int lat, output int busyCycles);
    bit seen;
    seen = 1'b0;
    lat = 0;
    busyCycles = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.done_o === 1'b1) seen = 1'b1;
      else if (bus.busy_o === 1'b1) busyCycles++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: no done_o within %0d cycles, required", lat);
    end
  endtask

  vec_t        vecs[14];
  int          lat, busyC, doneCount, busyCount;
  bit          seen;
  logic [2:0]  rf;
  logic [31:0] ra, rb;
  logic [4:0]  rrd;
  int          sel;

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 32};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33, 32};
    vecs[2]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 33, 32};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33, 32};
    vecs[4]  = '{3'b100, 32'd7,          32'd0,         5'd4,  32'hFFFF_FFFF, 1,  0};
    vecs[5]  = '{3'b111, 32'd7,          32'd0,         5'd6,  32'd7,         1,  0};
    vecs[6]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1,  0};
    vecs[7]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'd0,         1,  0};
    vecs[8]  = '{3'b101, 32'd100,        32'd7,         5'd10, 32'd14,        33, 32};
    vecs[9]  = '{3'b111, 32'd100,        32'd7,         5'd11, 32'd2,         33, 32};
    vecs[10] = '{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd12, 32'hFFFF_FFFD, 33, 32};
    vecs[11] = '{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd13, 32'hFFFF_FFFF, 33, 32};
    vecs[12] = '{3'b101, 32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF, 1,  0};
    vecs[13] = '{3'b110, 32'hFFFF_FFF9,  32'd0,         5'd15, 32'hFFFF_FFF9, 1,  0};

    rst_n          = 1'b0;
    bus.start_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.func3_i    = 3'd0;
    bus.rs1_data_i = 32'd0;
    bus.rs2_data_i = 32'd0;
    bus.rd_i       = 5'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",   32'(bus.busy_o),   32'd0);
    checkOutput("reset_done",   32'(bus.done_o),   32'd0);
    checkOutput("reset_result", bus.result_o,      32'd0);
    checkOutput("reset_rd",     32'(bus.rd_o),     32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd);
      waitDone(lat, busyC);
      checkOutput($sformatf("vec%0d_result", i), bus.result_o, vecs[i].exp);
      checkOutput($sformatf("vec%0d_rd", i), 32'(bus.rd_o), 32'(vecs[i].rd));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d_busy_cycles", i), 32'(busyC), 32'(vecs[i].busy));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), 32'(bus.done_o), 32'd0);
    end

    // Back-to-back: second op issued while the first is in DONE.
    applyStimulus(1'b1, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    waitDone(lat, busyC);
    checkOutput("b2b_first_result", bus.result_o, 32'hFFFF_FFEB);
    applyStimulus(1'b0, 3'b011, 32'hFFFF_FFFF, 32'd2, 5'd17);
    waitDone(lat, busyC);
    checkOutput("b2b_gap", 32'(lat), 32'd33);
    checkOutput("b2b_busy_cycles", 32'(busyC), 32'd32);
    checkOutput("b2b_second_result", bus.result_o, 32'd1);
    checkOutput("b2b_second_rd", 32'(bus.rd_o), 32'd17);

    // Flush and start in the same cycle: flush wins.
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.flush_i    = 1'b1;
    bus.func3_i    = 3'b000;
    bus.rs1_data_i = 32'd3;
    bus.rs2_data_i = 32'd3;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    checkOutput("flush_prio_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("flush_prio_result", bus.result_o, 32'd1);

    // start_i pulsed mid-DIV must be ignored.
    applyStimulus(1'b1, 3'b101, 32'd100, 32'd7, 5'd3);
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      if (i == 5) begin
        bus.start_i    = 1'b1;
        bus.func3_i    = 3'b000;
        bus.rs1_data_i = 32'd9;
        bus.rs2_data_i = 32'd9;
        bus.rd_i       = 5'd9;
      end else begin
        bus.start_i = 1'b0;
      end
      if (bus.done_o === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    bus.start_i = 1'b0;
    checkOutput("ignore_latency", 32'(lat), 32'd33);
    checkOutput("ignore_result", bus.result_o, 32'd14);
    checkOutput("ignore_rd", 32'(bus.rd_o), 32'd3);

    // Flush at iteration 10 of a divide.
    applyStimulus(1'b1, 3'b101, 32'd100, 32'd7, 5'd7);
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("flush_done", 32'(bus.done_o), 32'd0);
    doneCount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) doneCount++;
    end
    checkOutput("flush_no_done", 32'(doneCount), 32'd0);
    checkOutput("flush_result_hold", bus.result_o, 32'd14);
    checkOutput("flush_rd_hold", 32'(bus.rd_o), 32'd3);

    for (int i = 0; i < 40; i++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 50); end
        default: ;
      endcase
      rrd = 5'($urandom_range(0, 31));
      applyStimulus(1'b1, rf, ra, rb, rrd);
      waitDone(lat, busyC);
      checkOutput($sformatf("rand%0d_f%0d_%08h_%08h_result", i, rf, ra, rb),
                  bus.result_o, refModel(rf, ra, rb));
      checkOutput($sformatf("rand%0d_rd", i), 32'(bus.rd_o), 32'(rrd));
      checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'(refLatency(rf, ra, rb)));
    end

    // Reset in the middle of a multiply.
    applyStimulus(1'b1, 3'b000, 32'd7, 32'd3, 5'd4);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy",   32'(bus.busy_o), 32'd0);
    checkOutput("midreset_done",   32'(bus.done_o), 32'd0);
    checkOutput("midreset_result", bus.result_o,    32'd0);
    checkOutput("midreset_rd",     32'(bus.rd_o),   32'd0);
    rst_n = 1'b1;
    doneCount = 0;
    busyCount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) doneCount++;
      if (bus.busy_o === 1'b1) busyCount++;
    end
    checkOutput("midreset_no_done", 32'(doneCount), 32'd0);
    checkOutput("midreset_no_busy", 32'(busyCount), 32'd0);

    applyStimulus(1'b1, 3'b111, 32'd100, 32'd7, 5'd11);
    waitDone(lat, busyC);
    checkOutput("recover_result", bus.result_o, 32'd2);
    checkOutput("recover_latency", 32'(lat), 32'd33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
